spi_ram: RTL and testbench
==========================

# spi_ram

Command-decoding single-port RAM that sits directly downstream of `SPI_Slave`. It consumes the slave's 10-bit `rx_data`/`rx_valid` word stream and decodes bits [9:8] as a command and bits [7:0] as the payload. It returns read data to the slave through `tx_data`/`tx_valid` for serial shift-out on MISO. Together with `SPI_Slave` it forms the SPI-to-memory wrapper.

## Interface
Parameters:
- `MEM_DEPTH`, 256, number of 8-bit words.
- `ADDR_SIZE`, 8, address width; `MEM_DEPTH` ≤ 2**`ADDR_SIZE`.

Ports:
- `SCLK` input 1: the single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input 10: command word from `SPI_Slave.rx_data`.
- `rx_valid` input 1: `din` valid, level-held by the slave for several cycles.
- `dout` output 8: read data, to `SPI_Slave.tx_data`.
- `tx_valid` output 1: `dout` valid, to `SPI_Slave.tx_valid`.
- `cmd_err` output 1: one-cycle pulse when an illegal command sequence occurs.

## Operation
- **Acceptance:** a command is accepted only on the rising edge of `rx_valid`, i.e. `rx_valid`=1 and registered `rx_valid_d`=0. A held `rx_valid` executes exactly once.
- **Commands** (decoded from `din[9:8]`):
  - 00 write-address: `wr_addr` ← `din[ADDR_SIZE-1:0]`.
  - 01 write-data: `mem[wr_addr]` ← `din[7:0]`.
  - 10 read-address: `rd_addr` ← `din[ADDR_SIZE-1:0]`.
  - 11 read-data: `dout` ← `mem[rd_addr]` and `tx_valid` ← 1.
- **FSM states:** `IDLE`, `WR_RDY`, `RD_RDY`.
  - From any state, cmd 00 → `WR_RDY` and cmd 10 → `RD_RDY`.
  - cmd 01 executes only in `WR_RDY` (state unchanged). In any other state: no write, `cmd_err` pulses, state unchanged.
  - cmd 11 executes only in `RD_RDY` (state unchanged). In any other state: no read, `tx_valid` unchanged, `cmd_err` pulses.
- **tx_valid:** once set, holds along with `dout` until the next accepted command of any kind, which clears it. This covers the slave's 8-bit MISO shift.
- **Out-of-range address** (value ≥ `MEM_DEPTH`): writes are dropped, reads return 8'h00, and `cmd_err` pulses.
- **Reset values:** state `IDLE`; `wr_addr`, `rd_addr`, `rx_valid_d`, `dout` = 0; `tx_valid` = 0; `cmd_err` = 0. Memory contents are not reset.
- **Reset mid-operation:** all registers clear immediately. A pending write does not commit.

## Timing
- **Latency 1:** an edge accepted at `SCLK` edge k updates `mem`, `dout`, `tx_valid` and `cmd_err` at edge k, visible in cycle k+1.
- **Write-then-read:** a read-data issued to the address of an earlier write returns the new data. No bypass is needed because commands are at least 2 cycles apart.
- **Reset release:** if `rx_valid`=1 in the first cycle after reset release, that counts as a rising edge and the command executes.
- **`cmd_err`:** high for exactly one cycle per illegal command.
- **Back-to-back:** `rx_valid` low for 1 cycle then high again gives a new command. The minimum command spacing is 2 cycles.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined: after each executed write-data, `wr_addr` increments; after each executed read-data, `rd_addr` increments. Both wrap from `MEM_DEPTH-1` to 0. An 8-bit burst therefore needs one address command.
- Undefined: addresses change only on cmd 00/10.

## Structure
- Package `spi_pkg`: command encodings `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11; the FSM state typedef; data width 8 and frame width 10. `SPI_Slave` also uses the frame width.
- Sub-module `spi_ram_core`: plain synchronous single-port 8-bit RAM with no reset, parameterised by `MEM_DEPTH`/`ADDR_SIZE`. Decode, FSM, edge detect and handshake stay in `spi_ram`.

## Test plan
- Write then read:
  - Stimulus: after reset, din=10'h0_05 (cmd 00), then 10'h1_A5 (cmd 01), then 10'h2_05 (cmd 10), then 10'h3_00 (cmd 11).
  - Expected: the cycle after the 4th edge, `dout`=8'hA5 and `tx_valid`=1; `tx_valid` holds until the next accepted command.
- Held `rx_valid`:
  - Stimulus: din=10'h1_3C held with `rx_valid`=1 for 10 cycles in `WR_RDY`.
  - Expected: exactly one write; no `cmd_err`.
- Sequence errors:
  - Stimulus: cmd 01 or cmd 11 issued in `IDLE`.
  - Expected: `cmd_err` pulses for 1 cycle; memory unchanged; `tx_valid` stays 0.
- Out of range:
  - Stimulus: `MEM_DEPTH`=200, write-address 8'hF0, then a write-data.
  - Expected: `cmd_err` pulses; a subsequent read of 8'hF0 returns 8'h00.
- Auto-increment (`SPI_RAM_AUTOINC_EN`):
  - Stimulus: write-address 8'hFF, then data 11 and 22.
  - Expected: `mem[255]`=11 and `mem[0]`=22; reads from 8'hFF return 11 then 22.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 while `tx_valid`=1.
  - Expected: `tx_valid`, `dout` and `cmd_err` go to 0 immediately, asynchronously; state returns to `IDLE` and the next cmd 11 flags `cmd_err`.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: command encodings, RAM FSM states and widths.
// SPI_Slave also uses FRAME_W.
package spi_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WR_RDY = 2'b01,
        RD_RDY = 2'b10
    } state_e;

    // Addresses are widened to 32 bits so the compare is valid for any ADDR_SIZE.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/spi_ram_core.sv
// Plain single-port 8-bit RAM: synchronous write, combinational read, no reset.
module spi_ram_core
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    // Write port; the caller only asserts i_we for in-range addresses.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/spi_ram.sv
// Command-decoding RAM behind SPI_Slave: edge-detects rx_valid, decodes din[9:8],
// drives tx_data/tx_valid back. Optional SPI_RAM_AUTOINC_EN adds address auto-increment.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic               SCLK,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    output logic               cmd_err
);

    state_e                r_state;
    logic [ADDR_SIZE-1:0]  r_wr_addr;
    logic [ADDR_SIZE-1:0]  r_rd_addr;
    logic                  r_rx_valid_d;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_tx_valid;
    logic                  r_cmd_err;

    state_e                w_state_nxt;
    logic [ADDR_SIZE-1:0]  w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0]  w_rd_addr_nxt;
    logic [DATA_W-1:0]     w_dout_nxt;
    logic                  w_tx_valid_nxt;
    logic                  w_cmd_err_nxt;
    logic                  w_mem_we;
    logic [ADDR_SIZE-1:0]  w_mem_addr;
    logic [DATA_W-1:0]     w_mem_rdata;

    logic                  w_accept;
    cmd_e                  w_cmd;
    logic [ADDR_SIZE-1:0]  w_addr_in;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign w_accept   = rx_valid & ~r_rx_valid_d;
    assign w_cmd      = cmd_e'(din[FRAME_W-1:FRAME_W-2]);
    assign w_addr_in  = din[ADDR_SIZE-1:0];
    assign w_wr_ok    = in_range(32'(r_wr_addr), 32'(MEM_DEPTH));
    assign w_rd_ok    = in_range(32'(r_rd_addr), 32'(MEM_DEPTH));
    // Only one command executes per cycle, so one shared RAM port suffices.
    assign w_mem_addr = (w_cmd == CMD_WR_DATA) ? r_wr_addr : r_rd_addr;

    spi_ram_core #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_core (
        .i_clk   (SCLK),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (din[DATA_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Command decode and FSM next-state; all registered outputs computed here.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_dout_nxt     = r_dout;
        w_tx_valid_nxt = r_tx_valid;
        w_cmd_err_nxt  = 1'b0;
        w_mem_we       = 1'b0;
        if (w_accept) begin
            w_tx_valid_nxt = 1'b0;
            case (w_cmd)
                CMD_WR_ADDR: begin
                    w_wr_addr_nxt = w_addr_in;
                    w_state_nxt   = WR_RDY;
                end
                CMD_RD_ADDR: begin
                    w_rd_addr_nxt = w_addr_in;
                    w_state_nxt   = RD_RDY;
                end
                CMD_WR_DATA: begin
                    if ((r_state == WR_RDY) && w_wr_ok) begin
                        w_mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                        w_wr_addr_nxt = (r_wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ?
                                        '0 : r_wr_addr + ADDR_SIZE'(1);
`else
                        w_wr_addr_nxt = r_wr_addr;
`endif
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (r_state == RD_RDY) begin
                        w_tx_valid_nxt = 1'b1;
                        if (w_rd_ok) begin
                            w_dout_nxt = w_mem_rdata;
`ifdef SPI_RAM_AUTOINC_EN
                            w_rd_addr_nxt = (r_rd_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ?
                                            '0 : r_rd_addr + ADDR_SIZE'(1);
`else
                            w_rd_addr_nxt = r_rd_addr;
`endif
                        end else begin
                            w_dout_nxt    = 8'h00;
                            w_cmd_err_nxt = 1'b1;
                        end
                    end else begin
                        w_tx_valid_nxt = r_tx_valid;
                        w_cmd_err_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end else begin
            w_tx_valid_nxt = r_tx_valid;
        end
    end

    // State and output registers.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rx_valid_d <= 1'b0;
            r_dout       <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_rx_valid_d <= rx_valid;
            r_dout       <= w_dout_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram.sv
// Directed self-checking bench for spi_ram: a 256-deep instance plus a 200-deep
// instance on the same stimulus for the out-of-range cases.
module tb_spi_ram;

    logic       SCLK = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout, dout2;
    logic       tx_valid, tx_valid2;
    logic       cmd_err, cmd_err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 SCLK = ~SCLK;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .SCLK(SCLK), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err)
    );

    spi_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut2 (
        .SCLK(SCLK), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout2), .tx_valid(tx_valid2), .cmd_err(cmd_err2)
    );

    // One command: a low cycle, then rx_valid high; returns at the negedge after acceptance.
    task automatic send(input logic [9:0] w);
        rx_valid = 1'b0;
        @(negedge SCLK);
        din      = w;
        rx_valid = 1'b1;
        @(negedge SCLK);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge SCLK);
        rst_n = 1'b0;
        @(negedge SCLK);
        @(negedge SCLK);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; din = 10'h000;
        @(negedge SCLK);
        n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want %h", dout, 8'h00); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
        @(negedge SCLK);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        send(10'h005);
        send(10'h1A5);
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_err got %b want 0", cmd_err); end
        send(10'h205);
        send(10'h300);
        n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_dout got %h want %h", dout, 8'hA5); end
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_tx_valid got %b want 1", tx_valid); end
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL wr_rd_cmd_err got %b want 0", cmd_err); end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rx_valid = 1'b0;
            @(negedge SCLK);
            n_tests++;
            if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
                n_fail++; $display("FAIL tx_hold cycle %0d got tx=%b dout=%h want tx=1 dout=a5", i, tx_valid, dout);
            end
        end
        send(10'h000);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_clear got %b want 0", tx_valid); end
    endtask

    task automatic test_held_rx_valid();
        send(10'h010);
        rx_valid = 1'b0;
        @(negedge SCLK);
        din = 10'h13C; rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge SCLK);
            if (i == 3) din = 10'h1C3;  // a second execution would now overwrite with C3
            n_tests++;
            if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL held_cmd_err cycle %0d got %b want 0", i, cmd_err); end
        end
        send(10'h210);
        send(10'h300);
        n_tests++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL held_once_dout got %h want %h", dout, 8'h3C); end
    endtask

    task automatic test_seq_err();
        send(10'h000);
        send(10'h15A);
        do_reset();
        send(10'h1FF);
        n_tests++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL seq_wr_cmd_err got %b want 1", cmd_err); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wr_tx_valid got %b want 0", tx_valid); end
        rx_valid = 1'b0;
        @(negedge SCLK);
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_pulse_width got %b want 0", cmd_err); end
        send(10'h300);
        n_tests++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL seq_rd_cmd_err got %b want 1", cmd_err); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL seq_rd_tx_valid got %b want 0", tx_valid); end
        send(10'h200);
        send(10'h300);
        n_tests++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL seq_mem_unchanged got %h want %h", dout, 8'h5A); end
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL seq_ok_cmd_err got %b want 0", cmd_err); end
    endtask

    task automatic test_out_of_range();
        send(10'h0F0);
        send(10'h177);
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_inrange_err got %b want 0", cmd_err); end
        n_tests++; if (cmd_err2 !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %b want 1", cmd_err2); end
        send(10'h2F0);
        send(10'h300);
        n_tests++; if (dout !== 8'h77) begin n_fail++; $display("FAIL oor_inrange_dout got %h want %h", dout, 8'h77); end
        n_tests++; if (dout2 !== 8'h00) begin n_fail++; $display("FAIL oor_rd_dout got %h want %h", dout2, 8'h00); end
        n_tests++; if (tx_valid2 !== 1'b1) begin n_fail++; $display("FAIL oor_rd_tx_valid got %b want 1", tx_valid2); end
        n_tests++; if (cmd_err2 !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err got %b want 1", cmd_err2); end
    endtask

    task automatic test_back_to_back();
        send(10'h030);
        send(10'h111);
        send(10'h031);
        send(10'h122);
        send(10'h230);
        send(10'h300);
        n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL b2b_first got %h want %h", dout, 8'h11); end
        send(10'h231);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_clear got %b want 0", tx_valid); end
        send(10'h300);
        n_tests++; if (dout !== 8'h22 || cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got dout=%h err=%b want dout=22 err=0", dout, cmd_err);
        end
    endtask

    task automatic test_reset_release();
        rx_valid = 1'b0;
        @(negedge SCLK);
        rst_n = 1'b0; din = 10'h205; rx_valid = 1'b1;
        @(negedge SCLK);
        @(negedge SCLK);
        rst_n = 1'b1;
        @(negedge SCLK);
        send(10'h300);
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL release_accept_err got %b want 0", cmd_err); end
        n_tests++; if (dout !== 8'hA5 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL release_accept_rd got dout=%h tx=%b want dout=a5 tx=1", dout, tx_valid);
        end
    endtask

    task automatic test_reset_mid();
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_precond_tx got %b want 1", tx_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (tx_valid !== 1'b0 || dout !== 8'h00 || cmd_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_clear got tx=%b dout=%h err=%b want 0/00/0", tx_valid, dout, cmd_err);
        end
        rx_valid = 1'b0;
        @(negedge SCLK);
        rst_n = 1'b1;
        send(10'h300);
        n_tests++; if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_idle_rd got err=%b tx=%b want err=1 tx=0", cmd_err, tx_valid);
        end
    endtask

`ifdef SPI_RAM_AUTOINC_EN
    task automatic test_autoinc();
        send(10'h0FF);
        send(10'h111);
        send(10'h122);
        send(10'h2FF);
        send(10'h300);
        n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL autoinc_ff got %h want %h", dout, 8'h11); end
        send(10'h300);
        n_tests++; if (dout !== 8'h22) begin n_fail++; $display("FAIL autoinc_wrap got %h want %h", dout, 8'h22); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_held_rx_valid();
        test_seq_err();
        test_out_of_range();
        test_back_to_back();
`ifdef SPI_RAM_AUTOINC_EN
        test_autoinc();
`endif
        test_reset_release();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
